conv_pool_sequencer: RTL and testbench

Layer sequencer for the CONV2/CONV3 stages. It walks the full output-pooled loop nest: row j, column i, filter ch, pool window w (0..3) and tap t (0..8). For each step it issues feature-map read addresses and the time-aligned MAC, pool and write strobes. It sits between the layer-level control FSM and the feature SRAM, the MAC array, the max-pool comparator and the output buffer.

---
 rtl/conv_seq_pkg.sv | 50 +++++
 rtl/conv_seq_delay.sv | 32 +++
 rtl/conv_pool_sequencer.sv | 242 ++++++++++++++++++++++++
 tb/tb_conv_pool_sequencer.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_seq_pkg.sv
// conv_seq_pkg: shared types for the CONV2/CONV3 layer sequencer.
// FSM states, per-read sideband, pool-stage sideband, tap geometry helpers.
package conv_seq_pkg;

  localparam int TAPS = 9;
  localparam int WINS = 4;
  localparam int AW   = 9;
  localparam int CW   = 5;
  localparam int CHW  = 7;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic           vld;
    logic           tap0;
    logic           tap8;
    logic           win0;
    logic           win3;
    logic [CW-1:0]  i;
    logic [CW-1:0]  j;
    logic [CHW-1:0] ch;
  } sb_t;

  typedef struct packed {
    logic           vld;
    logic           win0;
    logic           win3;
    logic [CW-1:0]  i;
    logic [CW-1:0]  j;
    logic [CHW-1:0] ch;
  } pool_t;

  function automatic logic [1:0] tapCol(
    input logic [3:0] t
  );
    return 2'(t % 4'd3);
  endfunction

  function automatic logic [1:0] tapRow(
    input logic [3:0] t
  );
    return 2'(t / 4'd3);
  endfunction

endpackage

// File: rtl/conv_seq_delay.sv
// conv_seq_delay: DEPTH-stage shift register, async reset, sync flush.
// Ports: iCLK, iRSTn, iFLUSH, iD[W] in; oQ[W] = iD delayed DEPTH cycles.
module conv_seq_delay #(
  parameter int DEPTH = 1,
  parameter int W     = 1
) (
  input  logic         iCLK,
  input  logic         iRSTn,
  input  logic         iFLUSH,
  input  logic [W-1:0] iD,
  output logic [W-1:0] oQ
);

  logic [W-1:0] stg [DEPTH];

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      for (int k = 0; k < DEPTH; k++)
        stg[k] <= '0;
    end else if (iFLUSH) begin
      for (int k = 0; k < DEPTH; k++)
        stg[k] <= '0;
    end else begin
      stg[0] <= iD;
      for (int k = 1; k < DEPTH; k++)
        stg[k] <= stg[k-1];
    end
  end

  assign oQ = stg[DEPTH-1];

endmodule

// File: rtl/conv_pool_sequencer.sv
// conv_pool_sequencer: walks j,i,ch,w,t; issues reads + aligned MAC/pool/write.
// In: iCLK iRSTn iSTART iSTALL [iABORT if CONV_SEQ_ABORT_EN]; out: busy/done/strobes.
module conv_pool_sequencer
  import conv_seq_pkg::*;
#(
  parameter int WIDTH   = 14,
  parameter int HEIGHT  = 18,
  parameter int NCH     = 112,
  parameter int RD_LAT  = 1,
  parameter int MAC_LAT = 2
) (
  input  logic           iCLK,
  input  logic           iRSTn,
  input  logic           iSTART,
  input  logic           iSTALL,
`ifdef CONV_SEQ_ABORT_EN
  input  logic           iABORT,
`endif
  output logic           oBUSY,
  output logic           oDONE,
  output logic           oRd_EN,
  output logic [AW-1:0]  oRd_ADDR,
  output logic           oMAC_EN,
  output logic           oMAC_CLR,
  output logic           oPOOL_EN,
  output logic           oPOOL_CLR,
  output logic           oWr_EN,
  output logic [AW-1:0]  oWr_ADDR,
  output logic [CHW-1:0] oCH
);

  localparam int DRAIN_CYC = RD_LAT + MAC_LAT + 1;

  state_t         state;
  logic [3:0]     tCnt;
  logic [1:0]     wCnt;
  logic [CHW-1:0] chCnt;
  logic [CW-1:0]  iCnt;
  logic [CW-1:0]  jCnt;
  logic           fin;
  logic [2:0]     drainCnt;
  sb_t            sbNow;
  sb_t            sbRd;
  sb_t            macSb;
  pool_t          poolIn;
  pool_t          poolSb;
  logic [9:0]     xPos;
  logic [9:0]     yPos;
  logic [9:0]     rdAddr;
  logic           chLast;
  logic           iLast;
  logic           jLast;
  logic           lastRead;
  logic           issue;
  logic           abort;

`ifdef CONV_SEQ_ABORT_EN
  assign abort = iABORT &&
    (state == RUN || state == DRAIN);
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    xPos = {4'd0, iCnt, 1'b0}
         + {9'd0, wCnt[0]}
         + {8'd0, tapCol(tCnt)};
    yPos = {4'd0, jCnt, 1'b0}
         + {9'd0, wCnt[1]}
         + {8'd0, tapRow(tCnt)};
    rdAddr = xPos + yPos * 10'(WIDTH);
  end

  always_comb begin
    sbNow      = '0;
    sbNow.vld  = 1'b1;
    sbNow.tap0 = (tCnt == 4'd0);
    sbNow.tap8 = (tCnt == 4'(TAPS-1));
    sbNow.win0 = (wCnt == 2'd0);
    sbNow.win3 = (wCnt == 2'(WINS-1));
    sbNow.i    = iCnt;
    sbNow.j    = jCnt;
    sbNow.ch   = chCnt;
  end

  assign chLast = (chCnt == CHW'(NCH-1));
  assign iLast  = (iCnt == CW'(WIDTH/2-1));
  assign jLast  = (jCnt == CW'(HEIGHT/2-1));
  assign lastRead = sbNow.tap8 && sbNow.win3
    && chLast && iLast && jLast;

  // fin keeps RUN alive for the cycle the final read is on the bus
  assign issue = !iSTALL && !fin && !abort &&
    (state == RUN || (state == IDLE && iSTART));

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state    <= IDLE;
      tCnt     <= '0;
      wCnt     <= '0;
      chCnt    <= '0;
      iCnt     <= '0;
      jCnt     <= '0;
      fin      <= 1'b0;
      drainCnt <= '0;
      sbRd     <= '0;
      oBUSY    <= 1'b0;
      oDONE    <= 1'b0;
      oRd_EN   <= 1'b0;
      oRd_ADDR <= '0;
    end else if (abort) begin
      state    <= IDLE;
      tCnt     <= '0;
      wCnt     <= '0;
      chCnt    <= '0;
      iCnt     <= '0;
      jCnt     <= '0;
      fin      <= 1'b0;
      drainCnt <= '0;
      sbRd     <= '0;
      oBUSY    <= 1'b0;
      oDONE    <= 1'b0;
      oRd_EN   <= 1'b0;
      oRd_ADDR <= '0;
    end else begin
      oDONE  <= 1'b0;
      oRd_EN <= issue;
      sbRd   <= issue ? sbNow : '0;
      if (issue) begin
        oRd_ADDR <= AW'(rdAddr);
        if (lastRead)
          fin <= 1'b1;
        if (!sbNow.tap8) begin
          tCnt <= tCnt + 4'd1;
        end else begin
          tCnt <= '0;
          if (!sbNow.win3) begin
            wCnt <= wCnt + 2'd1;
          end else begin
            wCnt <= '0;
            if (!chLast) begin
              chCnt <= chCnt + CHW'(1);
            end else begin
              chCnt <= '0;
              if (!iLast) begin
                iCnt <= iCnt + CW'(1);
              end else begin
                iCnt <= '0;
                jCnt <= jLast ? '0 : jCnt + CW'(1);
              end
            end
          end
        end
      end
      unique case (state)
        IDLE: begin
          if (iSTART) begin
            state <= RUN;
            oBUSY <= 1'b1;
          end
        end
        RUN: begin
          if (fin) begin
            state    <= DRAIN;
            fin      <= 1'b0;
            drainCnt <= '0;
          end
        end
        DRAIN: begin
          if (drainCnt == 3'(DRAIN_CYC-1)) begin
            state <= DONE;
            oBUSY <= 1'b0;
            oDONE <= 1'b1;
          end else begin
            drainCnt <= drainCnt + 3'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  conv_seq_delay #(
    .DEPTH(RD_LAT),
    .W($bits(sb_t))
  ) uMacDly (
    .iCLK(iCLK),
    .iRSTn(iRSTn),
    .iFLUSH(abort),
    .iD(sbRd),
    .oQ(macSb)
  );

  assign oMAC_EN  = macSb.vld;
  assign oMAC_CLR = macSb.tap0;

  // only the tap-8 MAC result is a finished sum worth pooling
  always_comb begin
    poolIn      = '0;
    poolIn.vld  = macSb.tap8;
    poolIn.win0 = macSb.tap8 & macSb.win0;
    poolIn.win3 = macSb.tap8 & macSb.win3;
    poolIn.i    = macSb.i;
    poolIn.j    = macSb.j;
    poolIn.ch   = macSb.ch;
  end

  conv_seq_delay #(
    .DEPTH(MAC_LAT),
    .W($bits(pool_t))
  ) uPoolDly (
    .iCLK(iCLK),
    .iRSTn(iRSTn),
    .iFLUSH(abort),
    .iD(poolIn),
    .oQ(poolSb)
  );

  assign oPOOL_EN  = poolSb.vld;
  assign oPOOL_CLR = poolSb.win0;

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      oWr_EN   <= 1'b0;
      oWr_ADDR <= '0;
      oCH      <= '0;
    end else if (abort) begin
      oWr_EN   <= 1'b0;
      oWr_ADDR <= '0;
      oCH      <= '0;
    end else begin
      oWr_EN <= poolSb.vld & poolSb.win3;
      if (poolSb.vld & poolSb.win3) begin
        oWr_ADDR <= AW'(poolSb.j) * AW'(WIDTH/2)
                  + AW'(poolSb.i);
        oCH      <= poolSb.ch;
      end
    end
  end

endmodule

// File: tb/tb_conv_pool_sequencer.sv
// tb_conv_pool_sequencer: scoreboard bench, CONV2 geometry with NCH=2.
// Reads are predicted per start; strobes are predicted per observed read.
module tb_conv_pool_sequencer;

  localparam int W    = 14;
  localparam int H    = 18;
  localparam int NC   = 2;
  localparam int RDL  = 1;
  localparam int MACL = 2;
  localparam int NRD  = (W/2)*(H/2)*NC*36;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic stall = 1'b0;
`ifdef CONV_SEQ_ABORT_EN
  logic abort = 1'b0;
`endif
  logic       busy, done, rdEn, macEn, macClr;
  logic       poolEn, poolClr, wrEn;
  logic [8:0] rdAddr, wrAddr;
  logic [6:0] ch;
  logic [32:0] outs;

  assign outs = {busy, done, rdEn, rdAddr, macEn, macClr,
                 poolEn, poolClr, wrEn, wrAddr, ch};

  conv_pool_sequencer #(
    .WIDTH(W), .HEIGHT(H), .NCH(NC),
    .RD_LAT(RDL), .MAC_LAT(MACL)
  ) dut (
    .iCLK(clk),
    .iRSTn(rst_n),
    .iSTART(start),
    .iSTALL(stall),
`ifdef CONV_SEQ_ABORT_EN
    .iABORT(abort),
`endif
    .oBUSY(busy),
    .oDONE(done),
    .oRd_EN(rdEn),
    .oRd_ADDR(rdAddr),
    .oMAC_EN(macEn),
    .oMAC_CLR(macClr),
    .oPOOL_EN(poolEn),
    .oPOOL_CLR(poolClr),
    .oWr_EN(wrEn),
    .oWr_ADDR(wrAddr),
    .oCH(ch)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   cyc;
    logic clr;
    int   addr;
    int   ch;
  } ev_t;

  ev_t macQ[$];
  ev_t poolQ[$];
  ev_t wrQ[$];
  int  expQ[$];
  bit  monOn = 1'b0;

  int checks = 0;
  int errors = 0;
  int rdCnt, macCnt, poolCnt, wrCnt, doneCnt;
  int lastRdAddr, lastWrAddr, lastCh;
  int lastRdCyc, lastWrCyc, doneCyc;

  function automatic int modelAddr(input int k);
    int t = k % 9;
    int w = (k / 9) % 4;
    int i = (k / (36*NC)) % (W/2);
    int j = k / (36*NC*(W/2));
    return ((2*i + w%2 + t%3) + (2*j + w/2 + t/3)*W) % 512;
  endfunction

  task automatic clearSb();
    macQ.delete();
    poolQ.delete();
    wrQ.delete();
    expQ.delete();
    rdCnt = 0; macCnt = 0; poolCnt = 0;
    wrCnt = 0; doneCnt = 0;
    lastRdAddr = -1; lastWrAddr = -1; lastCh = -1;
    lastRdCyc = -1; lastWrCyc = -1; doneCyc = -1;
  endtask

  always @(negedge clk) begin : mon
    int t, w, e;
    ev_t ev;
    if (monOn) begin
      if (rdEn) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("FAIL rd_extra: got read %0d, expected none",
                   rdAddr);
        end else begin
          e = expQ.pop_front();
          if (rdAddr !== e[8:0]) begin
            errors++;
            $display("FAIL rd_addr #%0d: got %0d expected %0d",
                     rdCnt, rdAddr, e);
          end
        end
        t = rdCnt % 9;
        w = (rdCnt / 9) % 4;
        macQ.push_back('{cyc + RDL, t == 0, 0, 0});
        if (t == 8)
          poolQ.push_back('{cyc + RDL + MACL, w == 0, 0, 0});
        if (t == 8 && w == 3)
          wrQ.push_back('{cyc + RDL + MACL + 1, 1'b0,
                          rdCnt / (36*NC), (rdCnt / 36) % NC});
        rdCnt++;
        lastRdAddr = int'(rdAddr);
        lastRdCyc  = cyc;
      end
      if (macEn) begin
        macCnt++;
        checks++;
        if (macQ.size() == 0 || macQ[0].cyc != cyc) begin
          errors++;
          $display("FAIL mac_time: got strobe at %0d, expected %0d",
                   cyc, macQ.size() ? macQ[0].cyc : -1);
        end else begin
          ev = macQ.pop_front();
          if (macClr !== ev.clr) begin
            errors++;
            $display("FAIL mac_clr: got %b expected %b",
                     macClr, ev.clr);
          end
        end
      end
      if (macQ.size() > 0 && macQ[0].cyc <= cyc) begin
        checks++;
        errors++;
        $display("FAIL mac_missing: got none, expected at %0d",
                 macQ[0].cyc);
        void'(macQ.pop_front());
      end
      if (poolEn) begin
        poolCnt++;
        checks++;
        if (poolQ.size() == 0 || poolQ[0].cyc != cyc) begin
          errors++;
          $display("FAIL pool_time: got strobe at %0d, expected %0d",
                   cyc, poolQ.size() ? poolQ[0].cyc : -1);
        end else begin
          ev = poolQ.pop_front();
          if (poolClr !== ev.clr) begin
            errors++;
            $display("FAIL pool_clr: got %b expected %b",
                     poolClr, ev.clr);
          end
        end
      end
      if (poolQ.size() > 0 && poolQ[0].cyc <= cyc) begin
        checks++;
        errors++;
        $display("FAIL pool_missing: got none, expected at %0d",
                 poolQ[0].cyc);
        void'(poolQ.pop_front());
      end
      if (wrEn) begin
        wrCnt++;
        checks++;
        lastWrAddr = int'(wrAddr);
        lastCh     = int'(ch);
        lastWrCyc  = cyc;
        if (wrQ.size() == 0 || wrQ[0].cyc != cyc) begin
          errors++;
          $display("FAIL wr_time: got strobe at %0d, expected %0d",
                   cyc, wrQ.size() ? wrQ[0].cyc : -1);
        end else begin
          ev = wrQ.pop_front();
          if (int'(wrAddr) != ev.addr || int'(ch) != ev.ch) begin
            errors++;
            $display("FAIL wr_data: got %0d/%0d expected %0d/%0d",
                     wrAddr, ch, ev.addr, ev.ch);
          end
        end
      end
      if (wrQ.size() > 0 && wrQ[0].cyc <= cyc) begin
        checks++;
        errors++;
        $display("FAIL wr_missing: got none, expected at %0d",
                 wrQ[0].cyc);
        void'(wrQ.pop_front());
      end
      if ((!busy && rdEn) || (busy && done)) begin
        checks++;
        errors++;
        $display("FAIL busy_flag: got busy=%b rd=%b done=%b",
                 busy, rdEn, done);
      end
      if (done) begin
        doneCnt++;
        doneCyc = cyc;
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_outs: got %h expected 0", outs);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL idle_outs: got %h expected 0", outs);
    end
  endtask

  task automatic runFull(input string tag, input int stallPct,
                         input bit poke, input bit firstChk);
    int cycles;
    int bound;
    int ex;
    int base[9] = '{0, 1, 2, 14, 15, 16, 28, 29, 30};
    clearSb();
    for (int k = 0; k < NRD; k++)
      expQ.push_back(modelAddr(k));
    bound = 3 * NRD + 200;
    monOn = 1'b1;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    if (firstChk) begin
      for (int k = 1; k <= 40; k++) begin
        @(negedge clk);
        if (k == 1) begin
          checks++;
          if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_busy1: got %b expected 1", tag, busy);
          end
        end
        if (k <= 36) begin
          ex = base[(k-1)%9] + ((k-1)/9)%2 + ((k-1)/18)*14;
          checks++;
          if (rdEn !== 1'b1 || int'(rdAddr) != ex) begin
            errors++;
            $display("FAIL %s_first_rd%0d: got %b/%0d expected 1/%0d",
                     tag, k-1, rdEn, rdAddr, ex);
          end
        end
        if (k == 11 || k == 12) begin
          checks++;
          if (macEn !== 1'b1 || macClr !== (k == 11)) begin
            errors++;
            $display("FAIL %s_mac_clr9: got %b/%b cyc %0d", tag,
                     macEn, macClr, k);
          end
        end
        if (k == 39) begin
          checks++;
          if (wrEn !== 1'b0) begin
            errors++;
            $display("FAIL %s_wr_early: got %b expected 0", tag, wrEn);
          end
        end
        if (k == 40) begin
          checks++;
          if (wrEn !== 1'b1 || wrAddr !== 9'd0 || ch !== 7'd0) begin
            errors++;
            $display("FAIL %s_first_wr: got %b/%0d/%0d expected 1/0/0",
                     tag, wrEn, wrAddr, ch);
          end
        end
      end
    end
    cycles = 0;
    while (doneCnt == 0 && cycles < bound) begin
      @(posedge clk);
      #1;
      stall = (stallPct > 0) &&
              ($urandom_range(99) < stallPct);
      start = poke && (cycles == 50);
      cycles++;
    end
    stall = 1'b0;
    start = 1'b0;
    checks++;
    if (doneCnt == 0) begin
      errors++;
      $display("FAIL %s_done_timeout: got none in %0d cycles", tag,
               bound);
    end
    repeat (10) @(posedge clk);
    #1 monOn = 1'b0;
    checks++;
    if (doneCnt != 1) begin
      errors++;
      $display("FAIL %s_done_count: got %0d expected 1", tag, doneCnt);
    end
    checks++;
    if (rdCnt != NRD || expQ.size() != 0) begin
      errors++;
      $display("FAIL %s_rd_count: got %0d expected %0d", tag,
               rdCnt, NRD);
    end
    checks++;
    if (macCnt != NRD || poolCnt != NRD/9 || wrCnt != NRD/36) begin
      errors++;
      $display("FAIL %s_strobe_counts: got %0d/%0d/%0d expected %0d/%0d/%0d",
               tag, macCnt, poolCnt, wrCnt, NRD, NRD/9, NRD/36);
    end
    checks++;
    if (lastRdAddr != 281) begin
      errors++;
      $display("FAIL %s_last_rd: got %0d expected 281", tag,
               lastRdAddr);
    end
    checks++;
    if (lastWrAddr != 62 || lastCh != NC-1) begin
      errors++;
      $display("FAIL %s_last_wr: got %0d/%0d expected 62/%0d", tag,
               lastWrAddr, lastCh, NC-1);
    end
    checks++;
    if (doneCyc != lastWrCyc + 1 ||
        doneCyc != lastRdCyc + RDL + MACL + 2) begin
      errors++;
      $display("FAIL %s_done_cyc: got %0d expected %0d", tag,
               doneCyc, lastRdCyc + RDL + MACL + 2);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy_end: got %b expected 0", tag, busy);
    end
  endtask

  task automatic test_reset_mid_run();
    int bad;
    clearSb();
    for (int k = 0; k < NRD; k++)
      expQ.push_back(modelAddr(k));
    monOn = 1'b1;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (300) @(posedge clk);
    #1 monOn = 1'b0;
    checks++;
    if (rdEn !== 1'b1) begin
      errors++;
      $display("FAIL mid_running: got rd=%b expected 1", rdEn);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL mid_async_rst: got %h expected 0", outs);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    clearSb();
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (outs !== '0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mid_stray: got %0d active cycles expected 0", bad);
    end
  endtask

`ifdef CONV_SEQ_ABORT_EN
  task automatic test_abort();
    int n;
    int bad;
    clearSb();
    for (int k = 0; k < NRD; k++)
      expQ.push_back(modelAddr(k));
    monOn = 1'b1;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (rdCnt < 500 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rdCnt < 500) begin
      errors++;
      $display("FAIL abort_reach: got %0d reads expected 500", rdCnt);
    end
    @(posedge clk);
    #1 abort = 1'b1;
    start = 1'b1;
    monOn = 1'b0;
    @(posedge clk);
    #1 abort = 1'b0;
    start = 1'b0;
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL abort_idle: got %h expected 0", outs);
    end
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (outs !== '0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL abort_stray: got %0d active cycles expected 0",
               bad);
    end
    runFull("restart", 0, 1'b0, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    runFull("plain", 0, 1'b0, 1'b1);
    test_reset_mid_run();
    runFull("stall", 30, 1'b1, 1'b0);
`ifdef CONV_SEQ_ABORT_EN
    test_abort();
`endif
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
